// File: rtl/ex_mem_buffer.sv
// Elastic DEPTH-entry FIFO between execute and memory stages, with flush and occupancy.
// Optional zero-latency fall-through when empty: define EX_MEM_BYPASS_EN.
module ex_mem_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 7,
  parameter int DEPTH        = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         ex_valid,
  output logic                         ex_ready,
  input  logic [DATA_WIDTH-1:0]        ex_alu_result,
  input  logic [DATA_WIDTH-1:0]        ex_rs2_data,
  input  logic                         ex_zero,
  input  logic [OPCODE_WIDTH-1:0]      ex_opcode,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [DATA_WIDTH-1:0]        mem_alu_result,
  output logic [DATA_WIDTH-1:0]        mem_rs2_data,
  output logic                         mem_zero,
  output logic [OPCODE_WIDTH-1:0]      mem_opcode,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = 2*DATA_WIDTH + 1 + OPCODE_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_alive;

  logic               w_push;
  logic               w_pop;
  logic               w_wr_en;
  logic               w_rd_en;
  logic               w_bypass;
  logic [ENTRY_W-1:0] w_ex_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_out_entry;

  // Holds ex_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  always_comb begin
    w_ex_entry = {ex_alu_result, ex_rs2_data, ex_zero, ex_opcode};
    w_head     = r_mem[r_rd_ptr];
    ex_ready   = r_alive && (r_count != FULL_CNT) && !flush;
`ifdef EX_MEM_BYPASS_EN
    w_bypass    = r_alive && (r_count == '0) && ex_valid && !flush;
    mem_valid   = ((r_count != '0) && !flush) || w_bypass;
    w_out_entry = w_bypass ? w_ex_entry : w_head;
`else
    w_bypass    = 1'b0;
    mem_valid   = (r_count != '0);
    w_out_entry = w_head;
`endif
    {mem_alu_result, mem_rs2_data, mem_zero, mem_opcode} = w_out_entry;
    count = r_count;
  end

  // A fall-through entry consumed in the same cycle never touches storage.
  always_comb begin
    w_push  = ex_valid && ex_ready;
    w_pop   = mem_valid && mem_ready;
    w_wr_en = w_push && !(w_bypass && mem_ready);
    w_rd_en = w_pop && !w_bypass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_ex_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Randomized and directed checks of ex_mem_buffer against a queue-based reference model.
module tb_ex_mem_buffer;

  localparam int DW    = 32;
  localparam int OW    = 7;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef EX_MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] rs2;
    logic          zero;
    logic [OW-1:0] opc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_rs2_data;
  logic          ex_zero;
  logic [OW-1:0] ex_opcode;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_rs2_data;
  logic          mem_zero;
  logic [OW-1:0] mem_opcode;
  logic [CW-1:0] count;

  ex_mem_buffer #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .ex_zero(ex_zero), .ex_opcode(ex_opcode),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
    .mem_zero(mem_zero), .mem_opcode(mem_opcode),
    .count(count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t m_q[$];
  bit   m_alive;
  bit   m_held;
  logic [DW-1:0] m_popped[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_ex(input bit vld, input logic [DW-1:0] v);
    ex_valid      = vld;
    ex_alu_result = v;
    ex_rs2_data   = ~v;
    ex_zero       = v[0];
    ex_opcode     = v[OW-1:0];
  endtask

  // One clock: check outputs at negedge against the model, advance model at posedge.
  task automatic step();
    ent_t in, head;
    bit   exp_rdy, exp_vld, byp;
    @(negedge clk);
    in.alu = ex_alu_result; in.rs2 = ex_rs2_data; in.zero = ex_zero; in.opc = ex_opcode;
    exp_rdy = m_alive && (m_q.size() < DEPTH) && !flush;
    byp     = BYP && m_alive && (m_q.size() == 0) && ex_valid && !flush;
    exp_vld = ((m_q.size() != 0) && !(BYP && flush)) || byp;
    chk("ex_ready", ex_ready, exp_rdy);
    chk("mem_valid", mem_valid, exp_vld);
    chk("count", count, m_q.size());
    if (exp_vld) begin
      head = byp ? in : m_q[0];
      chk("mem_alu_result", mem_alu_result, head.alu);
      chk("mem_rs2_data", mem_rs2_data, head.rs2);
      chk("mem_zero", mem_zero, head.zero);
      chk("mem_opcode", mem_opcode, head.opc);
      if (mem_ready) m_popped.push_back(mem_alu_result);
    end
    m_held = ex_valid && !exp_rdy;
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin
        m_q.delete();
      end else if (byp) begin
        if (!mem_ready) m_q.push_back(in);
      end else begin
        if (exp_vld && mem_ready) void'(m_q.pop_front());
        if (ex_valid && exp_rdy) m_q.push_back(in);
      end
      m_alive = 1'b1;
    end
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_count", count, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_ex_ready", ex_ready, 0);
    chk("rst_mem_alu", mem_alu_result, 0);
    chk("rst_mem_opcode", mem_opcode, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    set_ex(1'b0, '0);
    m_alive = 1'b0; m_held = 1'b0;
    #1;
    check_reset_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();          // no edge since release yet: ex_ready still low
    step();

    // Streaming, always ready.
    mem_ready = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      set_ex(1'b1, DW'(i * 32'h10));
      step();
    end
    set_ex(1'b0, '0);
    repeat (3) step();

    // Backpressure to full, held producer, then drain.
    mem_ready = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      set_ex(1'b1, DW'(32'hA + i));
      step();
    end
    chk("full_count", count, DEPTH);
    set_ex(1'b1, 32'hA + DEPTH);
    step(); step();
    mem_ready = 1'b1;
    step(); step();
    set_ex(1'b0, '0);
    repeat (DEPTH + 2) step();

    // Wrap-around at count 3: outputs must be 1..10 in order.
    m_popped.delete();
    mem_ready = 1'b0;
    for (int unsigned v = 1; v <= 3; v++) begin
      set_ex(1'b1, DW'(v));
      step();
    end
    mem_ready = 1'b1;
    for (int unsigned v = 4; v <= 10; v++) begin
      set_ex(1'b1, DW'(v));
      step();
    end
    set_ex(1'b0, '0);
    repeat (5) step();
    chk("wrap_pop_count", m_popped.size(), 10);
    for (int i = 0; i < 10 && i < m_popped.size(); i++) begin
      chk("wrap_order", m_popped[i], i + 1);
    end

    // Flush with a concurrent push of 0x55.
    mem_ready = 1'b0;
    for (int unsigned v = 1; v <= 3; v++) begin
      set_ex(1'b1, DW'(32'h40 + v));
      step();
    end
    flush = 1'b1;
    set_ex(1'b1, 32'h55);
    step();
    flush = 1'b0;
    set_ex(1'b0, '0);
    step();
    chk("flush_count", count, 0);
    chk("flush_mem_valid", mem_valid, 0);

    // Empty buffer, opcode 0x23 presented with memory ready.
    mem_ready = 1'b1;
    set_ex(1'b1, 32'h0000_1023);
    step();
    set_ex(1'b0, '0);
    step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      flush     = ($urandom_range(0, 31) == 0);
      mem_ready = ($urandom_range(0, 99) < 55);
      if (!m_held) set_ex($urandom_range(0, 99) < 70, $urandom());
      step();
    end
    flush = 1'b0;

    // Asynchronous reset mid-burst with entries stored.
    mem_ready = 1'b0;
    for (int unsigned v = 0; v < 2; v++) begin
      set_ex(1'b1, DW'(32'h70 + v));
      step();
    end
    chk("pre_rst_count", count, m_q.size());
    set_ex(1'b0, '0);
    rst_n = 1'b0;
    m_q.delete();
    m_alive = 1'b0;
    m_held = 1'b0;
    #1;
    check_reset_state();
    set_ex(1'b1, 32'h99);
    #1;
    chk("rst_hold_mem_valid", mem_valid, 0);
    chk("rst_hold_ex_ready", ex_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_ex(1'b0, '0);
    step();
    step();
    set_ex(1'b1, 32'h123);
    mem_ready = 1'b1;
    step();
    set_ex(1'b0, '0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
